// File: rtl/n2t_gate_pkg.sv
// n2t_gate_pkg: op encoding, FSM state type and defaults shared by the gate checkers.
package n2t_gate_pkg;
  localparam int DEF_WIDTH = 8;
  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_MUX  = 3'd4;
  localparam logic [2:0] OP_NAND = 3'd5;
  typedef logic [1:0] state_t;
  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;
  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_NAND;
  endfunction
endpackage

// File: rtl/gate_ref_model.sv
// gate_ref_model: combinational golden value of a Nand2Tetris primitive, bitwise over WIDTH.
module gate_ref_model
  import n2t_gate_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  output logic [WIDTH-1:0] y
);
  assign y = op == OP_NOT  ? ~a :
             op == OP_AND  ? a & b :
             op == OP_OR   ? a | b :
             op == OP_XOR  ? a ^ b :
             op == OP_MUX  ? (s ? b : a) :
             op == OP_NAND ? ~(a & b) : '0;
endmodule

// File: rtl/gate_vector_checker.sv
// gate_vector_checker: streams {a,b,s,dut_out} vectors, checks them against gate_ref_model.
// GATE_CHECKER_STOP_ON_ERR_EN ends the run at the first mismatch.
module gate_vector_checker
  import n2t_gate_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             s,
  input  logic [WIDTH-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got
);
  state_t           state;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] num_q, acc_cnt, s1_idx;
  logic             s1_valid, s1_s;
  logic [WIDTH-1:0] s1_a, s1_b, s1_dut, exp_val;
  logic             hs, mis;
  gate_ref_model #(.WIDTH(WIDTH)) u_ref (
    .op(op_q),
    .a (s1_a),
    .b (s1_b),
    .s (s1_s),
    .y (exp_val)
  );
  assign busy     = state == RUN;
  assign done     = state == DONE;
  assign in_ready = busy && acc_cnt < num_q;
  assign hs       = in_valid && in_ready;
  assign mis      = s1_valid && exp_val != s1_dut;
  assign pass     = done && op_legal(op_q) && err_count == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= IDLE;
      op_q          <= '0;
      num_q         <= '0;
      acc_cnt       <= '0;
      s1_valid      <= 1'b0;
      s1_a          <= '0;
      s1_b          <= '0;
      s1_s          <= 1'b0;
      s1_dut        <= '0;
      s1_idx        <= '0;
      vec_count     <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (start && state != RUN) begin
      state         <= !op_legal(op) || num_vec == '0 ? DONE : RUN;
      op_q          <= op;
      num_q         <= num_vec;
      acc_cnt       <= '0;
      s1_valid      <= 1'b0;
      vec_count     <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_got <= '0;
    end else if (state == RUN) begin
      s1_valid <= hs;
      if (hs) begin
        s1_a    <= a;
        s1_b    <= b;
        s1_s    <= s;
        s1_dut  <= dut_out;
        s1_idx  <= acc_cnt;
        acc_cnt <= acc_cnt + CNT_W'(1);
      end
      if (s1_valid)
        vec_count <= vec_count + CNT_W'(1);
      if (mis) begin
        err_count <= err_count + CNT_W'(err_count != '1);
        if (err_count == '0) begin
          first_err_idx <= s1_idx;
          first_err_exp <= exp_val;
          first_err_got <= s1_dut;
        end
      end
`ifdef GATE_CHECKER_STOP_ON_ERR_EN
      if (mis) begin
        state    <= DONE;
        s1_valid <= 1'b0;
      end else if (vec_count == num_q && !s1_valid)
        state <= DONE;
`else
      if (vec_count == num_q && !s1_valid)
        state <= DONE;
`endif
    end
endmodule

// File: tb/tb_gate_vector_checker.sv
// tb_gate_vector_checker: directed and randomized runs checked against a behavioural gate model.
module tb_gate_vector_checker;
  localparam int W = 8;
  localparam int C = 16;
  logic         clk = 0, rst_n = 0, start = 0, in_valid = 0, s = 0;
  logic [2:0]   op = 0;
  logic [C-1:0] num_vec = 0;
  logic [W-1:0] a = 0, b = 0, dut_out = 0;
  logic         in_ready, busy, done, pass;
  logic [C-1:0] vec_count, err_count, first_err_idx;
  logic [W-1:0] first_err_exp, first_err_got;
  int checks = 0, errors = 0, hs_count = 0;
  logic [W-1:0] va[32], vb[32], vd[32];
  logic         vs[32];
  gate_vector_checker #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .num_vec(num_vec),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .s(s), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .vec_count(vec_count), .err_count(err_count),
    .first_err_idx(first_err_idx), .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (rst_n && in_valid && in_ready) hs_count++;
  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [W-1:0] gold(input int o, input logic [W-1:0] x, input logic [W-1:0] y, input logic sel);
    case (o)
      0: return ~x;
      1: return x & y;
      2: return x | y;
      3: return x ^ y;
      4: return sel ? y : x;
      5: return ~(x & y);
      default: return '0;
    endcase
  endfunction
  task automatic do_start(input int o, input int n);
    @(negedge clk);
    op = 3'(o);
    num_vec = C'(n);
    start = 1;
    @(negedge clk);
    start = 0;
  endtask
  task automatic fill(input int o, input int n, input logic [31:0] emask);
    for (int j = 0; j < n; j++) begin
      va[j] = W'($urandom);
      vb[j] = W'($urandom);
      vs[j] = 1'($urandom_range(0, 1));
      vd[j] = gold(o, va[j], vb[j], vs[j]) ^ (emask[j] ? W'($urandom_range(1, 255)) : W'(0));
    end
  endtask
  task automatic run(input string tag, input int o, input int n, input bit stall);
    int ee = 0, fi = 0, ev, i = 0, cyc = 0, k = 1, base;
    logic [W-1:0] fe = 0, fg = 0;
    for (int j = 0; j < n; j++)
      if (vd[j] !== gold(o, va[j], vb[j], vs[j])) begin
        if (ee == 0) begin
          fi = j;
          fe = gold(o, va[j], vb[j], vs[j]);
          fg = vd[j];
        end
        ee++;
      end
    ev = n;
`ifdef GATE_CHECKER_STOP_ON_ERR_EN
    if (ee > 0) begin
      ev = fi + 1;
      ee = 1;
    end
`endif
    do_start(o, n);
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".ready"}, in_ready, 1);
    base = hs_count;
    while (i < n && !done && cyc < 500) begin
      in_valid = stall ? (cyc % 2 == 0) : 1'b1;
      a = va[i];
      b = vb[i];
      s = vs[i];
      dut_out = vd[i];
      if (in_valid && in_ready) i++;
      @(negedge clk);
      cyc++;
    end
    if (!stall) in_valid = 0;
    while (!done && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, ".done"}, done, 1);
    if (ee == 0) chk({tag, ".latency"}, k, 3);
    chk({tag, ".vec_count"}, vec_count, ev);
    chk({tag, ".err_count"}, err_count, ee);
    chk({tag, ".pass"}, pass, ee == 0);
    chk({tag, ".ready_low"}, in_ready, 0);
`ifndef GATE_CHECKER_STOP_ON_ERR_EN
    repeat (2) @(negedge clk);
    chk({tag, ".accepted"}, hs_count - base, n);
`endif
    if (ee > 0) begin
      chk({tag, ".first_idx"}, first_err_idx, fi);
      chk({tag, ".first_exp"}, first_err_exp, fe);
      chk({tag, ".first_got"}, first_err_got, fg);
    end
    in_valid = 0;
  endtask
  initial begin
    @(negedge clk);
    chk("reset.busy", busy, 0);
    chk("reset.done", done, 0);
    chk("reset.pass", pass, 0);
    chk("reset.ready", in_ready, 0);
    chk("reset.vec", vec_count, 0);
    chk("reset.err", err_count, 0);
    chk("reset.first", {first_err_idx, first_err_exp, first_err_got}, 0);
    rst_n = 1;
    va[0] = 8'h00; va[1] = 8'hFF; va[2] = 8'h4E;
    for (int j = 0; j < 3; j++) begin
      vb[j] = W'($urandom);
      vs[j] = 0;
      vd[j] = ~va[j];
    end
    run("not_clean", 0, 3, 0);
    va[0] = 78; va[1] = 78; vb[0] = 2; vb[1] = 2; vs[0] = 0; vs[1] = 1;
    vd[0] = 78; vd[1] = 8'h00;
    run("mux_err", 4, 2, 0);
    chk("mux_err.exp_const", first_err_exp, 8'h02);
    fill(2, 4, 0);
    run("stall", 2, 4, 1);
    do_start(1, 0);
    chk("zero.done", done, 1);
    chk("zero.pass", pass, 1);
    do_start(7, 3);
    chk("rsv.done", done, 1);
    chk("rsv.pass", pass, 0);
    chk("rsv.err", err_count, 0);
    in_valid = 1;
    repeat (3) begin
      chk("rsv.ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 0;
    fill(3, 5, 0);
    do_start(3, 5);
    for (int j = 0; j < 2; j++) begin
      in_valid = 1; a = va[j]; b = vb[j]; s = vs[j]; dut_out = vd[j];
      @(negedge clk);
    end
    in_valid = 0;
    @(posedge clk);
    #1 rst_n = 0;
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.ready", in_ready, 0);
    chk("rst.vec", vec_count, 0);
    chk("rst.err", err_count, 0);
    @(negedge clk);
    chk("rst.vec_hold", vec_count, 0);
    rst_n = 1;
    run("after_rst", 3, 5, 0);
    fill(5, 5, 32'h2);
    run("stop_err", 5, 5, 0);
    for (int r = 0; r < 8; r++) begin
      int o, n;
      o = $urandom_range(0, 5);
      n = $urandom_range(1, 20);
      fill(o, n, $urandom & $urandom & $urandom);
      run("rnd", o, n, 1'($urandom_range(0, 1)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
